mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//   MEM/WB pipeline register, directly downstream of the 4 KB data memory.
//   - Samples the memory's combinational read word and the MEM-stage ALU result.
//   - Extracts and sign/zero-extends load data by opcode and byte offset.
//   - Supports stall/flush, flags misaligned loads, and counts retired instructions.
//   - Feeds the register-file write port and the EX forwarding mux.
// PARAMETERS
//   DW     32  data width (load data, ALU result, wb_data)
//   AW     12  byte-address width; only addr[1:0] is used for lane select
//   RW     5   register-index width
//   CNT_W  32  retire-counter width
// PORTS
//   clk           in   1      clock; all state updates on posedge
//   rst           in   1      synchronous, active-high reset
//   stall         in   1      hold all WB registers this cycle
//   flush         in   1      insert bubble into WB this cycle
//   in_valid      in   1      MEM stage holds a real instruction
//   op            in   6      MIPS opcode of the MEM-stage instruction
//   addr          in   AW     byte address driven to the data memory
//   dm_rdata      in   DW     data-memory read word (word at addr[AW-1:2])
//   alu_result    in   DW     MEM-stage ALU result
//   rd            in   RW     destination register
//   reg_write     in   1      instruction writes rd
//   mem_to_reg    in   1      1 = load data to rd, 0 = alu_result to rd
//   wb_valid      out  1      WB stage holds a real instruction
//   wb_reg_write  out  1      register-file write enable
//   wb_rd         out  RW     register-file write index
//   wb_data       out  DW     register-file write data
//   wb_misalign   out  1      captured load was misaligned; write killed
//   retire_cnt    out  CNT_W  count of valid instructions captured
// BEHAVIOUR
//   - Latency: 1 cycle, MEM inputs to WB outputs.
//   - Priority each posedge: rst > flush > stall > capture.
//   - rst: every output <= 0, including retire_cnt.
//   - flush: wb_valid, wb_reg_write, wb_misalign <= 0.
//     wb_rd and wb_data hold; retire_cnt holds. Flush overrides a simultaneous stall.
//   - stall (no flush): every output holds its value.
//   - capture: wb_valid <= in_valid; wb_rd <= rd.
//     wb_reg_write <= in_valid & reg_write & (rd != 0) & ~misalign.
//   - Byte lanes are little-endian: byte k = dm_rdata[8k+7:8k], k = addr[1:0].
//   - Load data by op (used when mem_to_reg = 1):
//       lb  100000  sign-extend byte k
//       lbu 100100  zero-extend byte k
//       lh  100001  sign-extend halfword: addr[1]=0 -> [15:0], 1 -> [31:16]
//       lhu 100101  zero-extend halfword, same lane select as lh
//       lw  100011  dm_rdata
//       any other op with mem_to_reg = 1: dm_rdata
//   - mem_to_reg = 0: wb_data <= alu_result; op and addr ignored.
//   - retire_cnt += 1 on capture when in_valid = 1, including misaligned loads.
//     Wraps from 2^CNT_W-1 to 0.
//   - Store-then-load ordering: the memory writes on negedge, so a load one
//     cycle after a store to the same word sees the new data. No bypass needed.
//   - A bubble (in_valid = 0) never writes, regardless of reg_write.
// CONFIGURATION
//   MEM_WB_MISALIGN_CHK_EN defined:
//     - misalign = mem_to_reg & in_valid & ((lh|lhu) & addr[0] | lw & (addr[1:0] != 0)).
//     - A misaligned load sets wb_misalign = 1 for the captured cycle.
//     - The write is killed: wb_reg_write = 0. wb_data is still loaded per the rules above.
//   MEM_WB_MISALIGN_CHK_EN undefined:
//     - misalign = 0 and wb_misalign is tied to 0.
//     - lh/lhu ignore addr[0]; lw ignores addr[1:0].
// TESTING
//   1. rst=1 for 2 cycles with random inputs -> all outputs 0, retire_cnt = 0.
//   2. lb, addr=0x003, dm_rdata=0x80FF_1234, rd=5 ->
//      next cycle wb_data=0xFFFF_FF80, wb_reg_write=1, wb_rd=5.
//      Same with lbu -> wb_data=0x0000_0080.
//   3. lh, addr=0x002, dm_rdata=0x8001_7FFF -> wb_data=0xFFFF_8001.
//      lh, addr=0x001:
//        with MEM_WB_MISALIGN_CHK_EN -> wb_misalign=1, wb_reg_write=0;
//        without it -> wb_data=0x0000_7FFF, wb_misalign=0.
//   4. Capture ALU op (alu_result=0x1234, rd=3), then stall=1 for 3 cycles -> outputs frozen.
//      Then stall=1 and flush=1 together -> wb_valid=0, wb_reg_write=0, retire_cnt unchanged.
//   5. rd=0 with reg_write=1 -> wb_reg_write=0.
//      in_valid=0 with reg_write=1 -> wb_reg_write=0, retire_cnt unchanged.
//   6. Preload retire_cnt near max (CNT_W=4 build), retire 3 valid ops from 14 -> 15, 0, 1.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load-lane extraction, stall/flush, retire count.
// Optional misaligned-load detection is enabled by MEM_WB_MISALIGN_CHK_EN.
module mem_wb_stage #(
    parameter int DW    = 32,
    parameter int AW    = 12,
    parameter int RW    = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [5:0]       op,
    input  logic [AW-1:0]    addr,
    input  logic [DW-1:0]    dm_rdata,
    input  logic [DW-1:0]    alu_result,
    input  logic [RW-1:0]    rd,
    input  logic             reg_write,
    input  logic             mem_to_reg,
    output logic             wb_valid,
    output logic             wb_reg_write,
    output logic [RW-1:0]    wb_rd,
    output logic [DW-1:0]    wb_data,
    output logic             wb_misalign,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;

    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [DW-1:0] load_data;
    logic [DW-1:0] next_data;
    logic          misalign;
    logic          next_we;
    logic          unused_addr;

    // Only the lane-select bits of the address matter here.
    assign unused_addr = ^addr[AW-1:2];

    always_comb begin
        lane_b = 8'h00;
        unique case (addr[1:0])
            2'd0: lane_b = dm_rdata[7:0];
            2'd1: lane_b = dm_rdata[15:8];
            2'd2: lane_b = dm_rdata[23:16];
            2'd3: lane_b = dm_rdata[31:24];
        endcase
    end

    assign lane_h = addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];

    always_comb begin
        load_data = dm_rdata;
        case (op)
            OP_LB:   load_data = {{(DW-8){lane_b[7]}}, lane_b};
            OP_LBU:  load_data = {{(DW-8){1'b0}}, lane_b};
            OP_LH:   load_data = {{(DW-16){lane_h[15]}}, lane_h};
            OP_LHU:  load_data = {{(DW-16){1'b0}}, lane_h};
            default: load_data = dm_rdata;
        endcase
    end

    assign next_data = mem_to_reg ? load_data : alu_result;

`ifdef MEM_WB_MISALIGN_CHK_EN
    assign misalign = mem_to_reg & in_valid &
        ((((op == OP_LH) | (op == OP_LHU)) & addr[0]) |
         ((op == OP_LW) & (addr[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    // A misaligned load still retires but must not touch the register file.
    assign next_we = in_valid & reg_write & (rd != '0) & ~misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            retire_cnt   <= '0;
        end else if (flush) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
        end else if (!stall) begin
            wb_valid     <= in_valid;
            wb_reg_write <= next_we;
            wb_rd        <= rd;
            wb_data      <= next_data;
            if (in_valid)
                retire_cnt <= retire_cnt + 1'b1;
        end
    end

`ifdef MEM_WB_MISALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (rst || flush)
            wb_misalign <= 1'b0;
        else if (!stall)
            wb_misalign <= misalign;
    end
`else
    assign wb_misalign = 1'b0;
`endif

endmodule
